// File: rtl/icache_pkg.sv
// Shared types and address-split constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  localparam int WORD_SEL_W    = 3;
  localparam int OFFSET_W      = 5;
  localparam int DEF_NUM_LINES = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int INDEX_W       = $clog2(DEF_NUM_LINES);
  localparam int TAG_W         = DEF_ADDR_W - OFFSET_W - INDEX_W;

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for each cache line; combinational lookup, synchronous install/clear.
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int IDX_W    = INDEX_W,
  parameter int TAG_BITS = TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_index,
  input  logic [TAG_BITS-1:0] rd_tag,
  output logic                hit,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [TAG_BITS-1:0] wr_tag
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tags are not cleared; a cleared valid bit already makes them irrelevant.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
    end
  end

  assign hit = valid[rd_index] && (tags[rd_index] == rd_tag);

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache with single-line refill handshake.
// Define ICACHE_PERF_CNT_EN to add the hit/miss performance counter ports.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p1_req_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int IDX_W    = $clog2(NUM_LINES);
  localparam int TAG_BITS = ADDR_W - OFFSET_W - IDX_W;

  state_t                 state, state_next;
  logic [ADDR_W-1:0]      miss_addr;
  logic [LINE_BITS-1:0]   lines [NUM_LINES];
  logic [LINE_BITS-1:0]   req_line;
  logic [IDX_W-1:0]       req_index, fill_index;
  logic [TAG_BITS-1:0]    req_tag, fill_tag;
  logic [WORD_SEL_W-1:0]  req_word;
  logic                   hit, lookup_hit, lookup_miss, refill;

  assign req_word   = p1_addr_i[OFFSET_W-1 -: WORD_SEL_W];
  assign req_index  = p1_addr_i[OFFSET_W +: IDX_W];
  assign req_tag    = p1_addr_i[ADDR_W-1 -: TAG_BITS];
  assign fill_index = miss_addr[OFFSET_W +: IDX_W];
  assign fill_tag   = miss_addr[ADDR_W-1 -: TAG_BITS];
  assign req_line   = lines[req_index];

  icache_tag_array #(
    .IDX_W    (IDX_W),
    .TAG_BITS (TAG_BITS)
  ) u_tags (
    .clk      (clk_i),
    .rst      (rst_i),
    .rd_index (req_index),
    .rd_tag   (req_tag),
    .hit      (hit),
    .wr_en    (refill),
    .wr_index (fill_index),
    .wr_tag   (fill_tag)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state <= state_next;
      if (lookup_miss) begin
        miss_addr <= p1_addr_i & ~ADDR_W'((1 << OFFSET_W) - 1);
      end
    end
  end

  // Refill ignores the live PC: the captured line address alone decides where data lands.
  always_comb begin
    state_next  = state;
    p1_data_o   = '0;
    p1_stall_o  = 1'b0;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    refill      = 1'b0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (p1_req_i) begin
            if (hit) begin
              lookup_hit = 1'b1;
              p1_data_o  = req_line[{req_word, 5'd0} +: 32];
            end else begin
              lookup_miss = 1'b1;
              p1_stall_o  = 1'b1;
              state_next  = MISS;
            end
          end
        end
        MISS: begin
          p1_stall_o = 1'b1;
          if (mem_ack_i) begin
            refill     = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (refill) begin
      lines[fill_index] <= mem_data_i;
    end
  end

  assign mem_enable_o = (state == MISS);
  assign mem_addr_o   = miss_addr;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (lookup_miss) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: random fetches against a direct-mapped cache model.
`timescale 1ns/1ps
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         p1_req = 1'b0;
  logic [31:0]  p1_addr = '0;
  logic [31:0]  p1_data;
  logic         p1_stall;
  logic         mem_enable;
  logic [31:0]  mem_addr;
  logic [255:0] mem_data = '0;
  logic         mem_ack = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
  logic [31:0]  m_hit = '0, m_miss = '0;
`endif

  icache_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .p1_req_i     (p1_req),
    .p1_addr_i    (p1_addr),
    .p1_data_o    (p1_data),
    .p1_stall_o   (p1_stall),
    .mem_enable_o (mem_enable),
    .mem_addr_o   (mem_addr),
    .mem_data_i   (mem_data),
    .mem_ack_i    (mem_ack)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          miss;
    bit          chk_stall;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] refill_q[$];
  int          errors = 0;
  int          checks = 0;
  int          stall_cnt = 0;
  int          last_delay = 0;
  int          force_delay = -1;
  bit          quiet = 1'b1;
  bit          resp_en = 1'b1;

  // Reference cache contents: which line address each of the 32 slots holds.
  bit          m_valid [32];
  logic [31:0] m_line  [32];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0193) ^ 32'h5EED_1234;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word(base + 32'(4 * i));
    return l;
  endfunction

  function automatic bit model_lookup(input logic [31:0] a);
    int          slot;
    logic [31:0] base;
    bit          miss;
    base = a & ~32'h1F;
    slot = int'((a / 32) % 32);
    miss = !(m_valid[slot] && m_line[slot] == base);
    m_valid[slot] = 1'b1;
    m_line[slot]  = base;
    return miss;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic check_perf(input string tag);
    check({tag, "_hit_cnt"}, hit_cnt, m_hit);
    check({tag, "_miss_cnt"}, miss_cnt, m_miss);
  endtask
`endif

  task automatic fetch(input logic [31:0] a);
    bit miss;
    int n;
    miss = model_lookup(a);
    exp_q.push_back('{mem_word(a & ~32'h3), miss, 1'b1});
    if (miss) refill_q.push_back(a & ~32'h1F);
`ifdef ICACHE_PERF_CNT_EN
    if (miss) m_miss++;
    m_hit++;
`endif
    p1_req  = 1'b1;
    p1_addr = a;
    n = 0;
    @(negedge clk);
    while (p1_stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: addr %h still stalled after %0d cycles, required release", a, n);
    end
    @(posedge clk);
    #1 p1_req = 1'b0;
  endtask

  task automatic wait_enable(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, mem_enable}, 32'd1);
  endtask

  // Monitor: pops one expectation whenever a fetch is delivered without stall.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !quiet) begin
        if (p1_req && p1_stall) begin
          stall_cnt++;
        end else if (p1_req) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: addr %h delivered, no fetch expected", p1_addr);
          end else begin
            e = exp_q.pop_front();
            check("fetch_data", p1_data, e.data);
            if (e.chk_stall) check("stall_cycles", 32'(stall_cnt), e.miss ? 32'(last_delay + 2) : 32'd0);
          end
          stall_cnt = 0;
        end else begin
          check("idle_data", p1_data, 32'd0);
          check("idle_stall", {31'd0, p1_stall}, 32'd0);
        end
      end
    end
  end

  // Memory responder: acks each refill after a chosen number of enable cycles.
  initial begin
    bit          active;
    int          en_cnt, cur_delay;
    logic [31:0] exp_line;
    active = 1'b0; en_cnt = 0; cur_delay = 0; exp_line = '0;
    forever begin
      @(negedge clk);
      if (resp_en && mem_ack) begin
        mem_ack = 1'b0;
        active  = 1'b0;
      end else if (resp_en && !rst && mem_enable) begin
        if (!active) begin
          active    = 1'b1;
          en_cnt    = 0;
          cur_delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
          last_delay = cur_delay;
          if (refill_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_refill: mem_enable high for %h, no miss expected", mem_addr);
            exp_line = '0;
          end else begin
            exp_line = refill_q.pop_front();
          end
        end
        check("refill_addr", mem_addr, exp_line);
        if (en_cnt == cur_delay) begin
          mem_ack  = 1'b1;
          mem_data = line_of(exp_line);
        end
        en_cnt++;
      end
    end
  end

  initial begin
    bit miss;
    logic [31:0] a;
    foreach (m_valid[i]) begin m_valid[i] = 1'b0; m_line[i] = '0; end

    @(negedge clk);
    check("rst_stall", {31'd0, p1_stall}, 32'd0);
    check("rst_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_data", p1_data, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    check_perf("rst");
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    quiet = 1'b0;

    // Cold miss with ack two cycles after enable rises, then same-line hits and eviction.
    force_delay = 2;
    fetch(32'h0000_0000);
    force_delay = -1;
    fetch(32'h0000_001C);
    fetch(32'h0000_0400);
    fetch(32'h0000_0000);
`ifdef ICACHE_PERF_CNT_EN
    check_perf("directed");
`endif

    // Reset while refilling, followed by a late ack.
    quiet = 1'b1;
    resp_en = 1'b0;
    p1_req = 1'b1;
    p1_addr = 32'h0000_0800;
    wait_enable("rstmiss_enable_up");
    @(posedge clk);
    #1 rst = 1'b1;
    p1_req = 1'b0;
    @(negedge clk);
    check("rstmiss_stall_in_reset", {31'd0, p1_stall}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ack = 1'b1;
    mem_data = {8{32'hBAD0_BAD0}};
    @(negedge clk);
    check("rstmiss_enable", {31'd0, mem_enable}, 32'd0);
    check("rstmiss_stall", {31'd0, p1_stall}, 32'd0);
    check("rstmiss_mem_addr", mem_addr, 32'd0);
    check("rstmiss_data", p1_data, 32'd0);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_enable", {31'd0, mem_enable}, 32'd0);
    foreach (m_valid[i]) m_valid[i] = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    m_hit = '0;
    m_miss = '0;
    check_perf("after_rst");
`endif
    stall_cnt = 0;
    quiet = 1'b0;
    resp_en = 1'b1;
    @(posedge clk);
    #1;

    // One miss followed by hits in the same line.
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0000_0008);
    fetch(32'h0000_000C);
    fetch(32'h0000_0010);
`ifdef ICACHE_PERF_CNT_EN
    check_perf("miss_then_hits");
`endif

    // PC moves during a refill: the captured line still gets installed.
    fetch(32'h0000_0400);
    miss = model_lookup(32'h0000_0000);
    if (miss) refill_q.push_back(32'h0000_0000);
`ifdef ICACHE_PERF_CNT_EN
    if (miss) m_miss++;
`endif
    force_delay = 3;
    p1_req = 1'b1;
    p1_addr = 32'h0000_0000;
    wait_enable("chg_enable_up");
    @(posedge clk);
    #1 p1_addr = 32'h0000_0020;
    force_delay = -1;
    miss = model_lookup(32'h0000_0020);
    exp_q.push_back('{mem_word(32'h0000_0020), miss, 1'b0});
    if (miss) refill_q.push_back(32'h0000_0020);
`ifdef ICACHE_PERF_CNT_EN
    if (miss) m_miss++;
    m_hit++;
`endif
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (p1_stall && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("chg_released", {31'd0, p1_stall}, 32'd0);
    end
    @(posedge clk);
    #1 p1_req = 1'b0;
    fetch(32'h0000_0000);

`ifdef ICACHE_PERF_CNT_EN
    check_perf("chg");
    dut.hit_cnt = 32'hFFFF_FFFF;
    m_hit = 32'hFFFF_FFFF;
    fetch(32'h0000_0000);
    check_perf("wrap");
`endif

    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
      fetch(a);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
`ifdef ICACHE_PERF_CNT_EN
    check_perf("random");
`endif

    repeat (3) @(posedge clk);
    check("pending_fetches", 32'(exp_q.size()), 32'd0);
    check("pending_refills", 32'(refill_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
